// File: rtl/scope_capture_pkg.sv
// scope_capture_pkg
//   Shared types and default sizes for the scope capture block.
//   state_t     : capture FSM states (IDLE/PRE/WAIT_TRIG/POST/READ)
//   trig_mode_t : trigger mode codes as presented on i_trig_mode
package scope_capture_pkg;

   localparam int SC_DW    = 16;
   localparam int SC_DEPTH = 64;
   localparam int SC_AW    = 6;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRE       = 3'd1,
      WAIT_TRIG = 3'd2,
      POST      = 3'd3,
      READ      = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      TRIG_IMM  = 2'b00,
      TRIG_RISE = 2'b01,
      TRIG_FALL = 2'b10,
      TRIG_BOTH = 2'b11
   } trig_mode_t;

endpackage

// File: rtl/scope_ram.sv
// scope_ram
//   DEPTH x DW simple dual-port RAM: synchronous write, registered read.
//   i_clk            clock
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr     read request; o_rdata valid the cycle after i_re
module scope_ram #(
   parameter int DW    = 16,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/scope_capture.sv
// scope_capture
//   Records samples (one per rising edge of i_smp_clk) into a circular buffer
//   around a level trigger, then streams the DEPTH-entry frame oldest-first.
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_smp_clk, i_smp_data             sample clock and sample value
//   i_arm, i_abort                    start capture / return to IDLE (pulses)
//   i_trig_mode, i_trig_level         trigger mode and threshold
//   i_pre_cnt                         samples kept before the trigger
//   o_rd_valid/o_rd_data/o_rd_last    read-out stream, i_rd_ready accepts
//   o_busy                            state != IDLE
//   o_done                            pulse after the final beat is accepted
import scope_capture_pkg::*;

module scope_capture #(
   parameter int DW    = SC_DW,
   parameter int DEPTH = SC_DEPTH,
   parameter int AW    = SC_AW
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_smp_clk,
   input  logic [DW-1:0] i_smp_data,
   input  logic          i_arm,
   input  logic          i_abort,
   input  logic [1:0]    i_trig_mode,
   input  logic [DW-1:0] i_trig_level,
   input  logic [AW-1:0] i_pre_cnt,
   output logic          o_rd_valid,
   output logic [DW-1:0] o_rd_data,
   output logic          o_rd_last,
   input  logic          i_rd_ready,
   output logic          o_busy,
   output logic          o_done
);

   state_t        r_state;
   trig_mode_t    r_mode;
   logic [DW-1:0] r_level;
   logic [AW-1:0] r_pre;
   logic          r_smp_clk_q;
   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_cnt;
   logic [DW-1:0] r_prev;
   logic          r_prev_valid;
   logic [AW-1:0] r_trig_addr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_issued;
   logic          r_pend;
   logic          r_pend_last;
   logic          r_skid_v;
   logic [DW-1:0] r_skid_d;
   logic          r_skid_last;

   logic          w_stb;
   logic          w_wr_en;
   logic          w_rise;
   logic          w_fall;
   logic          w_hit;
   logic [AW:0]   w_cnt_inc;
   logic [AW:0]   w_post_tgt;
   logic          w_pop;
   logic [1:0]    w_occ;
   logic          w_issue;
   logic          w_issue_last;
   logic [DW-1:0] w_ram_q;

   assign w_stb      = i_smp_clk & ~r_smp_clk_q;
   assign w_wr_en    = w_stb & ((r_state == PRE) | (r_state == WAIT_TRIG) | (r_state == POST));
   assign w_cnt_inc  = r_cnt + (AW+1)'(1);
   assign w_post_tgt = (AW+1)'(DEPTH) - {1'b0, r_pre};

   // Cross triggers need a previous stored sample from this capture.
   assign w_rise = r_prev_valid & (r_prev <  r_level) & (i_smp_data >= r_level);
   assign w_fall = r_prev_valid & (r_prev >= r_level) & (i_smp_data <  r_level);

   always_comb begin
      w_hit = 1'b0;
      case (r_mode)
         TRIG_IMM:  w_hit = 1'b1;
         TRIG_RISE: w_hit = w_rise;
         TRIG_FALL: w_hit = w_fall;
         TRIG_BOTH: w_hit = w_rise | w_fall;
         default:   w_hit = 1'b0;
      endcase
   end

   // Read issue: output reg + skid reg + one in-flight RAM read never exceed
   // two held beats, so a stall never loses data and 1 beat/clk is sustained.
   assign w_pop        = o_rd_valid & i_rd_ready;
   assign w_occ        = 2'(o_rd_valid) + 2'(r_skid_v) + 2'(r_pend) - 2'(w_pop);
   assign w_issue      = (r_state == READ) & (r_issued != (AW+1)'(DEPTH)) & (w_occ < 2'd2);
   assign w_issue_last = (r_issued == (AW+1)'(DEPTH-1));

   assign o_busy = (r_state != IDLE);

   scope_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_wr_en),
      .i_waddr (r_wr_ptr),
      .i_wdata (i_smp_data),
      .i_re    (w_issue),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_ram_q)
   );

   // Capture FSM
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_mode       <= TRIG_IMM;
         r_level      <= '0;
         r_pre        <= '0;
         r_smp_clk_q  <= 1'b0;
         r_wr_ptr     <= '0;
         r_cnt        <= '0;
         r_prev       <= '0;
         r_prev_valid <= 1'b0;
         r_trig_addr  <= '0;
         r_rd_ptr     <= '0;
         r_issued     <= '0;
         o_done       <= 1'b0;
      end else begin
         r_smp_clk_q <= i_smp_clk;
         o_done      <= 1'b0;
         if (w_wr_en) begin
            r_wr_ptr     <= r_wr_ptr + AW'(1);
            r_prev       <= i_smp_data;
            r_prev_valid <= 1'b1;
         end
         if (i_abort) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE: if (i_arm) begin
                  r_mode       <= trig_mode_t'(i_trig_mode);
                  r_level      <= i_trig_level;
                  r_pre        <= i_pre_cnt;
                  r_wr_ptr     <= '0;
                  r_cnt        <= '0;
                  r_prev_valid <= 1'b0;
                  r_state      <= (i_pre_cnt == '0) ? WAIT_TRIG : PRE;
               end
               PRE: if (w_stb) begin
                  if (w_cnt_inc == {1'b0, r_pre}) begin
                     r_cnt   <= '0;
                     r_state <= WAIT_TRIG;
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
               WAIT_TRIG: if (w_stb && w_hit) begin
                  r_trig_addr <= r_wr_ptr;
                  // Trigger sample is post-sample 1; if that is all, read now.
                  if (w_post_tgt == (AW+1)'(1)) begin
                     r_rd_ptr <= r_wr_ptr - r_pre;
                     r_issued <= '0;
                     r_state  <= READ;
                  end else begin
                     r_cnt   <= (AW+1)'(1);
                     r_state <= POST;
                  end
               end
               POST: if (w_stb) begin
                  if (w_cnt_inc == w_post_tgt) begin
                     r_rd_ptr <= r_trig_addr - r_pre;
                     r_issued <= '0;
                     r_state  <= READ;
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
               READ: begin
                  if (w_issue) begin
                     r_rd_ptr <= r_rd_ptr + AW'(1);
                     r_issued <= r_issued + (AW+1)'(1);
                  end
                  if (w_pop && o_rd_last) begin
                     r_state <= IDLE;
                     o_done  <= 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   // Read-out output register with one-entry skid for RAM latency
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pend      <= 1'b0;
         r_pend_last <= 1'b0;
         r_skid_v    <= 1'b0;
         r_skid_d    <= '0;
         r_skid_last <= 1'b0;
         o_rd_valid  <= 1'b0;
         o_rd_data   <= '0;
         o_rd_last   <= 1'b0;
      end else if (i_abort) begin
         r_pend     <= 1'b0;
         r_skid_v   <= 1'b0;
         o_rd_valid <= 1'b0;
         o_rd_last  <= 1'b0;
      end else begin
         r_pend      <= w_issue;
         r_pend_last <= w_issue_last;
         if (!o_rd_valid || w_pop) begin
            if (r_skid_v) begin
               o_rd_valid  <= 1'b1;
               o_rd_data   <= r_skid_d;
               o_rd_last   <= r_skid_last;
               r_skid_v    <= r_pend;
               r_skid_d    <= w_ram_q;
               r_skid_last <= r_pend_last;
            end else if (r_pend) begin
               o_rd_valid <= 1'b1;
               o_rd_data  <= w_ram_q;
               o_rd_last  <= r_pend_last;
            end else begin
               o_rd_valid <= 1'b0;
               o_rd_last  <= 1'b0;
            end
         end else if (r_pend) begin
            r_skid_v    <= 1'b1;
            r_skid_d    <= w_ram_q;
            r_skid_last <= r_pend_last;
         end
      end
   end

endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture
//   Scoreboard bench: expected frames are queued when a capture is started and
//   compared beat by beat as the DUT streams them out.
module tb_scope_capture;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        smp_clk = 1'b0;
   logic [15:0] smp_data = '0;
   logic        arm = 1'b0;
   logic        abort = 1'b0;
   logic [1:0]  trig_mode = '0;
   logic [15:0] trig_level = '0;
   logic [5:0]  pre_cnt = '0;
   logic        rd_ready = 1'b0;
   logic        rd_valid, rd_last, busy, done;
   logic [15:0] rd_data;

   scope_capture dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_smp_clk    (smp_clk),
      .i_smp_data   (smp_data),
      .i_arm        (arm),
      .i_abort      (abort),
      .i_trig_mode  (trig_mode),
      .i_trig_level (trig_level),
      .i_pre_cnt    (pre_cnt),
      .o_rd_valid   (rd_valid),
      .o_rd_data    (rd_data),
      .o_rd_last    (rd_last),
      .i_rd_ready   (rd_ready),
      .o_busy       (busy),
      .o_done       (done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, act, exp);
   endtask

   // scoreboard / monitor state
   logic [15:0] sb_q[$];
   int          beat = 0;
   bit          exp_done = 0;
   int          done_cnt = 0;
   bit          stall_q = 0;
   logic [15:0] stall_d;
   logic        stall_l;
   bit          rdy_toggle = 0;

   always @(posedge clk) begin
      #2;
      rd_ready = rdy_toggle ? ~rd_ready : 1'b1;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (done || exp_done) chk("done", done, exp_done);
         if (exp_done) chk("vld_after_last", rd_valid, 0);
         if (done) done_cnt++;
         exp_done = 0;
         if (stall_q) begin
            chk("hold_v", rd_valid, 1);
            chk("hold_d", rd_data, stall_d);
            chk("hold_l", rd_last, stall_l);
         end
         stall_q = rd_valid && !rd_ready;
         stall_d = rd_data;
         stall_l = rd_last;
         if (rd_valid && rd_ready) begin
            if (sb_q.size() == 0) chk("unexp_beat", 1, 0);
            else chk($sformatf("beat%0d", beat), rd_data, sb_q.pop_front());
            chk($sformatf("last%0d", beat), rd_last, beat == 63);
            if (beat == 63) begin exp_done = 1; beat = 0; end
            else beat++;
         end
      end else begin
         stall_q = 0;
      end
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic send_sample(input logic [15:0] d);
      step(); smp_clk = 1'b1; smp_data = d;
      step(); smp_clk = 1'b0;
   endtask

   // Arm, then scramble the trigger inputs: the DUT must use the latched copy.
   task automatic do_arm(input int mode, input int level, input int pre);
      step(); arm = 1'b1; trig_mode = 2'(mode); trig_level = 16'(level); pre_cnt = 6'(pre);
      step(); arm = 1'b0; trig_mode = ~trig_mode; trig_level = ~trig_level; pre_cnt = ~pre_cnt;
   endtask

   task automatic start_cap(input int mode, input int level, input int pre,
                            input int start, input int dir, input int nsmp,
                            input int exp_first, input int exp_dir);
      for (int i = 0; i < 64; i++) sb_q.push_back(16'(exp_first + i * exp_dir));
      do_arm(mode, level, pre);
      for (int k = 0; k < nsmp; k++) send_sample(16'(start + k * dir));
   endtask

   task automatic wait_done(input string tag);
      int d0;
      d0 = done_cnt;
      for (int t = 0; t < 1000 && done_cnt == d0; t++) @(negedge clk);
      chk({tag, "_done_seen"}, done_cnt, d0 + 1);
      chk({tag, "_sb_empty"}, sb_q.size(), 0);
      @(negedge clk);
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int d0;
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_last", rd_last, 0);
      chk("rst_data", rd_data, 0);
      chk("rst_done", done, 0);
      step(); rst_n = 1'b1;

      // 1: reset asserted mid-POST
      do_arm(0, 0, 0);
      for (int k = 0; k < 10; k++) send_sample(16'(k + 500));
      @(negedge clk);
      chk("post_busy", busy, 1);
      step(); rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", rd_valid, 0);
      chk("midrst_last", rd_last, 0);
      chk("midrst_done", done, 0);
      chk("midrst_data", rd_data, 0);
      step(); rst_n = 1'b1;

      // 2: immediate trigger, no pre-history, ramp
      start_cap(0, 0, 0, 0, 1, 64, 0, 1);
      wait_done("imm");

      // 3: rising cross at 100 with 8 pre samples
      start_cap(1, 100, 8, 90, 1, 66, 92, 1);
      wait_done("rise");

      // 4: falling cross at 50, descending data, stalled read-out
      rdy_toggle = 1;
      start_cap(2, 50, 4, 60, -1, 71, 53, -1);
      wait_done("fall");
      rdy_toggle = 0;
      repeat (2) step();

      // 5a: abort while waiting for a trigger that never comes
      do_arm(1, 1000, 0);
      for (int k = 0; k < 5; k++) send_sample(16'(k));
      @(negedge clk);
      chk("wait_busy", busy, 1);
      d0 = done_cnt;
      step(); abort = 1'b1;
      step(); abort = 1'b0;
      @(negedge clk);
      chk("abort_wait_busy", busy, 0);

      // 5b: abort during read-out beat 10
      start_cap(0, 0, 0, 0, 1, 64, 0, 1);
      for (int t = 0; t < 1000 && beat < 10; t++) @(negedge clk);
      chk("reach_beat10", beat, 10);
      step(); abort = 1'b1;
      step(); abort = 1'b0;
      sb_q.delete();
      beat = 0;
      @(negedge clk);
      chk("abort_rd_busy", busy, 0);
      chk("abort_rd_valid", rd_valid, 0);
      chk("abort_rd_last", rd_last, 0);
      repeat (10) @(negedge clk);
      chk("abort_no_done", done_cnt, d0);

      // 5c: arm and abort together
      step(); arm = 1'b1; abort = 1'b1; trig_mode = 2'b00; pre_cnt = '0;
      step(); arm = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("arm_abort_busy", busy, 0);
      send_sample(16'h1234);
      repeat (4) @(negedge clk);
      chk("arm_abort_idle", busy, 0);
      chk("arm_abort_no_done", done_cnt, d0);

      // 6: pre=63, either edge: trigger goes straight to READ, rd_ptr wraps
      start_cap(3, 70, 63, 0, 1, 71, 7, 1);
      wait_done("pre63");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

endmodule
